// File: rtl/pc_ras.sv
// Program counter with branch/jump/call/ret handling and a circular return-address stack.
// A full stack overwrites its oldest entry on call; overflow and underflow are sticky until reset.
module pc_ras #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         step,
    input  logic [2:0]                   op,
    input  logic [1:0]                   cond,
    input  logic [ADDR_W-1:0]            target,
    input  logic [DATA_W-1:0]            rs1_data,
    input  logic [DATA_W-1:0]            rs2_data,
    output logic [ADDR_W-1:0]            pc_out,
    output logic                         taken,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [2:0] OpJump   = 3'b001;
    localparam logic [2:0] OpBranch = 3'b010;
    localparam logic [2:0] OpCall   = 3'b011;
    localparam logic [2:0] OpRet    = 3'b100;

    localparam logic [1:0] CondEq  = 2'b00;
    localparam logic [1:0] CondNe  = 2'b01;
    localparam logic [1:0] CondLt  = 2'b10;
    localparam logic [1:0] CondLtu = 2'b11;

    localparam logic [CntW-1:0] CntFull = CntW'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              taken_q, taken_d;
    logic [CntW-1:0]   count_q, count_d;
    // sp_q points at the next slot to write; when full it also points at the oldest entry.
    logic [PtrW-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] stack_q [RAS_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [PtrW-1:0]   top_ptr;
    logic              ras_full;
    logic              ras_empty;
    logic              cond_true;
    logic              push;

    assign pc_inc    = pc_q + ADDR_W'(1);
    assign top_ptr   = sp_q - PtrW'(1);
    assign ras_full  = (count_q == CntFull);
    assign ras_empty = (count_q == '0);

    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            CondEq:  cond_true = (rs1_data == rs2_data);
            CondNe:  cond_true = (rs1_data != rs2_data);
            CondLt:  cond_true = ($signed(rs1_data) < $signed(rs2_data));
            CondLtu: cond_true = (rs1_data < rs2_data);
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        taken_d = 1'b0;
        count_d = count_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        if (step) begin
            case (op)
                OpJump: begin
                    pc_d    = target;
                    taken_d = 1'b1;
                end
                OpBranch: begin
                    pc_d    = cond_true ? target : pc_inc;
                    taken_d = cond_true;
                end
                OpCall: begin
                    push    = 1'b1;
                    pc_d    = target;
                    taken_d = 1'b1;
                    sp_d    = sp_q + PtrW'(1);
                    if (ras_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CntW'(1);
                    end
                end
                OpRet: begin
                    if (ras_empty) begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end else begin
                        pc_d    = stack_q[top_ptr];
                        taken_d = 1'b1;
                        sp_d    = top_ptr;
                        count_d = count_q - CntW'(1);
                    end
                end
                default: pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            taken_q <= 1'b0;
            count_q <= '0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
            count_q <= count_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entries are never cleared; only those below count_q are ever read.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            stack_q[sp_q] <= pc_inc;
        end
    end

    assign pc_out        = pc_q;
    assign taken         = taken_q;
    assign ras_count     = count_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_ras.sv
// Bench for pc_ras: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model of the program counter and stack.
module tb_pc_ras;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;
    localparam int RAS_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              step;
    logic [2:0]        op;
    logic [1:0]        cond;
    logic [ADDR_W-1:0] target;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [ADDR_W-1:0] pc_out;
    logic              taken;
    logic [2:0]        ras_count;
    logic              ras_overflow;
    logic              ras_underflow;

    pc_ras #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .step         (step),
        .op           (op),
        .cond         (cond),
        .target       (target),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .pc_out       (pc_out),
        .taken        (taken),
        .ras_count    (ras_count),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [ADDR_W-1:0] m_pc;
    bit                m_taken;
    bit                m_ovf;
    bit                m_unf;
    logic [ADDR_W-1:0] m_stack[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic bit cond_holds(input logic [1:0] c, input logic [31:0] a,
                                      input logic [31:0] b);
        case (c)
            2'd0:    return a == b;
            2'd1:    return a != b;
            2'd2:    return $signed(a) < $signed(b);
            default: return a < b;
        endcase
    endfunction

    task automatic model_step();
        logic [ADDR_W-1:0] nxt;
        nxt = m_pc + 16'd1;
        if (reset) begin
            m_pc    = '0;
            m_taken = 0;
            m_ovf   = 0;
            m_unf   = 0;
            m_stack.delete();
        end else begin
            m_taken = 0;
            if (step) begin
                case (op)
                    3'd1: begin m_pc = target; m_taken = 1; end
                    3'd2: begin
                        m_taken = cond_holds(cond, rs1_data, rs2_data);
                        m_pc    = m_taken ? target : nxt;
                    end
                    3'd3: begin
                        if (m_stack.size() == RAS_DEPTH) begin
                            void'(m_stack.pop_front());
                            m_ovf = 1;
                        end
                        m_stack.push_back(nxt);
                        m_pc    = target;
                        m_taken = 1;
                    end
                    3'd4: begin
                        if (m_stack.size() == 0) begin
                            m_unf = 1;
                            m_pc  = nxt;
                        end else begin
                            m_pc    = m_stack.pop_back();
                            m_taken = 1;
                        end
                    end
                    default: m_pc = nxt;
                endcase
            end
        end
    endtask

    task automatic compare_model();
        check("model pc_out", 32'(pc_out), 32'(m_pc));
        check("model taken", 32'(taken), 32'(m_taken));
        check("model ras_count", 32'(ras_count), 32'(m_stack.size()));
        check("model ras_overflow", 32'(ras_overflow), 32'(m_ovf));
        check("model ras_underflow", 32'(ras_underflow), 32'(m_unf));
    endtask

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic drive(input bit r, input bit s, input logic [2:0] o, input logic [15:0] t);
        reset  = r;
        step   = s;
        op     = o;
        target = t;
        cycle();
    endtask

    task automatic set_br(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        cond     = c;
        rs1_data = a;
        rs2_data = b;
    endtask

    initial begin
        set_br(2'd0, 32'd0, 32'd0);

        drive(1, 0, 3'd0, 16'h0);
        check("reset pc", 32'(pc_out), 32'h0);
        check("reset count", 32'(ras_count), 32'h0);
        check("reset taken", 32'(taken), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            drive(0, 1, 3'd0, 16'h0);
            check("seq pc", 32'(pc_out), 32'(i));
            check("seq taken", 32'(taken), 32'h0);
        end

        drive(0, 1, 3'd3, 16'h55);
        check("call before reset count", 32'(ras_count), 32'h1);
        drive(1, 1, 3'd3, 16'h77);
        check("reset over call pc", 32'(pc_out), 32'h0);
        check("reset over call count", 32'(ras_count), 32'h0);
        check("reset over call taken", 32'(taken), 32'h0);

        drive(0, 1, 3'd1, 16'h1);
        check("jump to pc+1 taken", 32'(taken), 32'h1);

        drive(0, 1, 3'd1, 16'h5);
        set_br(2'd2, 32'hFFFF_FFFF, 32'h1);
        drive(0, 1, 3'd2, 16'h40);
        check("branch lt pc", 32'(pc_out), 32'h40);
        check("branch lt taken", 32'(taken), 32'h1);
        drive(0, 1, 3'd1, 16'h5);
        set_br(2'd3, 32'hFFFF_FFFF, 32'h1);
        drive(0, 1, 3'd2, 16'h40);
        check("branch ltu pc", 32'(pc_out), 32'h6);
        check("branch ltu taken", 32'(taken), 32'h0);
        set_br(2'd0, 32'd0, 32'd0);

        drive(0, 1, 3'd1, 16'h10);
        drive(0, 1, 3'd3, 16'h80);
        check("call pc", 32'(pc_out), 32'h80);
        check("call count", 32'(ras_count), 32'h1);
        drive(0, 1, 3'd4, 16'h0);
        check("ret pc", 32'(pc_out), 32'h11);
        check("ret count", 32'(ras_count), 32'h0);
        check("ret taken", 32'(taken), 32'h1);

        drive(1, 0, 3'd0, 16'h0);
        for (int k = 1; k <= 5; k++) drive(0, 1, 3'd3, 16'(k * 256));
        check("overflow flag", 32'(ras_overflow), 32'h1);
        check("full count", 32'(ras_count), 32'h4);
        for (int k = 4; k >= 1; k--) begin
            drive(0, 1, 3'd4, 16'h0);
            check("deep ret pc", 32'(pc_out), 32'(k * 256 + 1));
        end
        drive(0, 1, 3'd4, 16'h0);
        check("underflow pc", 32'(pc_out), 32'h102);
        check("underflow flag", 32'(ras_underflow), 32'h1);
        check("underflow taken", 32'(taken), 32'h0);
        check("underflow count", 32'(ras_count), 32'h0);

        drive(0, 1, 3'd1, 16'hFFFF);
        drive(0, 1, 3'd0, 16'h0);
        check("wrap pc", 32'(pc_out), 32'h0);
        check("wrap taken", 32'(taken), 32'h0);
        drive(0, 0, 3'd1, 16'h1234);
        check("hold pc", 32'(pc_out), 32'h0);
        check("hold taken", 32'(taken), 32'h0);
        check("overflow sticky", 32'(ras_overflow), 32'h1);

        repeat (3000) begin
            logic [31:0] a;
            a = $urandom;
            case ($urandom_range(0, 2))
                0:       set_br(2'($urandom_range(0, 3)), a, a);
                1:       set_br(2'($urandom_range(0, 3)), a, $urandom);
                default: set_br(2'($urandom_range(0, 3)), 32'($signed(4'(a))),
                                32'($signed(4'($urandom))));
            endcase
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                  3'($urandom_range(0, 7)), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
